innerproduct_mac_stream: RTL and testbench

// Streaming, multi-class logistic-regression inner-product engine.
// - Accepts one pixel per beat from the line buffer and multiply-accumulates it against NUM_CLASS coefficient rows in parallel.
// - Emits all class scores plus the argmax once per frame.
// - The bias term is stored at coefficient address 0 and enters the sum as theta0 << FRAC_BITS (theta0 times the fixed-point 1.0).
// - Coefficients are runtime-loadable, not compiled in.

---
 rtl/innerproduct_mac_stream_if.sv | 37 +++
 rtl/innerproduct_mac_stream.sv | 156 +++++++++++++++
 tb/tb_innerproduct_mac_stream.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/innerproduct_mac_stream_if.sv
// Bundled coefficient-load port, pixel stream and score stream of the inner-product engine.
// master = producer/consumer around the engine, slave = the engine itself.
interface innerproduct_mac_stream_if #(
  parameter int N_FEAT    = 81,
  parameter int NUM_CLASS = 10,
  parameter int DATA_W    = 7,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = 32
);
  localparam int CLS_W  = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam int ADDR_W = $clog2(N_FEAT + 1);

  logic                        coef_we;
  logic [CLS_W-1:0]            coef_class;
  logic [ADDR_W-1:0]           coef_addr;
  logic [COEF_W-1:0]           coef_data;
  logic                        coef_busy;
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_W-1:0]           in_data;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_CLASS*ACC_W-1:0]  out_data;
  logic [CLS_W-1:0]            out_argmax;
  logic                        out_err;

  modport master (
    output coef_we, coef_class, coef_addr, coef_data, in_valid, in_data, in_last, out_ready,
    input  coef_busy, in_ready, out_valid, out_data, out_argmax, out_err
  );

  modport slave (
    input  coef_we, coef_class, coef_addr, coef_data, in_valid, in_data, in_last, out_ready,
    output coef_busy, in_ready, out_valid, out_data, out_argmax, out_err
  );
endinterface

// File: rtl/innerproduct_mac_stream.sv
// Streaming multi-class logistic-regression inner product: one pixel per beat is
// multiply-accumulated against NUM_CLASS coefficient rows; scores and argmax are emitted per frame.
module innerproduct_mac_stream #(
  parameter int N_FEAT    = 81,
  parameter int NUM_CLASS = 10,
  parameter int DATA_W    = 7,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = 32,
  parameter int FRAC_BITS = 16,
  parameter int SAT       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  innerproduct_mac_stream_if.slave   bus
);
  localparam int CLS_W  = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam int ADDR_W = $clog2(N_FEAT + 1);
  localparam int PROD_W = COEF_W + DATA_W + 1;
  localparam int W0     = (ACC_W > PROD_W) ? ACC_W : PROD_W;
  localparam int W1     = (W0 > COEF_W + FRAC_BITS) ? W0 : COEF_W + FRAC_BITS;
  localparam int SUM_W  = W1 + 1;

  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0]       LAST_CNT = ADDR_W'(N_FEAT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  // Reduce a wide exact sum to the accumulator width: clamp when saturating, otherwise wrap.
  function automatic logic signed [ACC_W-1:0] fit(input logic signed [SUM_W-1:0] v);
    if (SAT != 0 && v > ACC_MAX) return ACC_MAX[ACC_W-1:0];
    if (SAT != 0 && v < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    return v[ACC_W-1:0];
  endfunction

  logic [1:0]                 r_state;
  logic [ADDR_W-1:0]          r_cnt;
  logic                       r_valid;
  logic [CLS_W-1:0]           r_argmax;
  logic                       r_err;
  logic [COEF_W-1:0]          r_coef [NUM_CLASS][N_FEAT+1];

  logic                       w_accept;
  logic                       w_at_last;
  logic                       w_close;
  logic [ADDR_W-1:0]          w_rd_addr;
  logic [NUM_CLASS*ACC_W-1:0] w_next_flat;
  logic [NUM_CLASS*ACC_W-1:0] w_acc_flat;
  logic [CLS_W-1:0]           w_best_idx;
  logic signed [ACC_W-1:0]    w_best_val;

  assign bus.in_ready   = !rst && (r_state != S_HOLD);
  assign bus.coef_busy  = (r_state != S_IDLE);
  assign bus.out_valid  = r_valid;
  assign bus.out_argmax = r_argmax;
  assign bus.out_err    = r_err;
  assign bus.out_data   = w_acc_flat;

  assign w_accept  = bus.in_valid && bus.in_ready;
  assign w_at_last = (r_cnt == LAST_CNT);
  assign w_close   = w_accept && (bus.in_last || w_at_last);
  // cnt stays 0 in IDLE, so cnt+1 addresses the weight of the pixel currently on the bus.
  assign w_rd_addr = r_cnt + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (bus.coef_we && r_state == S_IDLE && int'(bus.coef_class) < NUM_CLASS
        && int'(bus.coef_addr) <= N_FEAT)
      r_coef[bus.coef_class][bus.coef_addr] <= bus.coef_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASS; gi++) begin : g_lane
      logic signed [COEF_W-1:0] w_theta0;
      logic signed [COEF_W-1:0] w_theta;
      logic signed [SUM_W-1:0]  w_bias_ext;
      logic signed [SUM_W-1:0]  w_bias_wide;
      logic signed [PROD_W-1:0] w_prod;
      logic signed [ACC_W-1:0]  w_base;
      logic signed [SUM_W-1:0]  w_base_ext;
      logic signed [SUM_W-1:0]  w_prod_ext;
      logic signed [ACC_W-1:0]  w_next;
      logic signed [ACC_W-1:0]  r_acc;

      assign w_theta0    = r_coef[gi][0];
      assign w_theta     = r_coef[gi][w_rd_addr];
      assign w_bias_ext  = {{(SUM_W-COEF_W){w_theta0[COEF_W-1]}}, w_theta0};
      assign w_bias_wide = w_bias_ext <<< FRAC_BITS;
      assign w_prod      = $signed({{(PROD_W-DATA_W){1'b0}}, bus.in_data})
                         * $signed({{(PROD_W-COEF_W){w_theta[COEF_W-1]}}, w_theta});
      assign w_base      = (r_state == S_IDLE) ? fit(w_bias_wide) : r_acc;
      assign w_base_ext  = {{(SUM_W-ACC_W){w_base[ACC_W-1]}}, w_base};
      assign w_prod_ext  = {{(SUM_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
      assign w_next      = fit(w_base_ext + w_prod_ext);

      // The accumulator doubles as the score output register, so scores appear with out_valid.
      always_ff @(posedge clk) begin
        if (rst)
          r_acc <= '0;
        else if (w_accept)
          r_acc <= w_next;
      end

      assign w_next_flat[gi*ACC_W +: ACC_W] = w_next;
      assign w_acc_flat[gi*ACC_W +: ACC_W]  = r_acc;
    end
  endgenerate

  // Argmax over the scores being committed this beat; strict '>' keeps ties on the lowest lane.
  always_comb begin
    w_best_idx = '0;
    w_best_val = w_next_flat[ACC_W-1:0];
    for (int c = 1; c < NUM_CLASS; c++) begin
      if ($signed(w_next_flat[c*ACC_W +: ACC_W]) > w_best_val) begin
        w_best_val = w_next_flat[c*ACC_W +: ACC_W];
        w_best_idx = CLS_W'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_argmax <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_accept) begin
            if (w_close) begin
              r_state  <= S_HOLD;
              r_cnt    <= '0;
              r_valid  <= 1'b1;
              r_argmax <= w_best_idx;
              r_err    <= (bus.in_last != w_at_last);
            end else begin
              r_state <= S_ACCUM;
              r_cnt   <= w_rd_addr;
            end
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_innerproduct_mac_stream.sv
// Directed bench: a small N_FEAT=4 / NUM_CLASS=2 engine plus two 16-bit engines
// (saturating and wrapping) for the overflow cases.
module tb_innerproduct_mac_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  innerproduct_mac_stream_if #(.N_FEAT(4), .NUM_CLASS(2), .DATA_W(7), .COEF_W(16), .ACC_W(32)) b0 ();
  innerproduct_mac_stream_if #(.N_FEAT(4), .NUM_CLASS(2), .DATA_W(7), .COEF_W(16), .ACC_W(16)) b1 ();
  innerproduct_mac_stream_if #(.N_FEAT(4), .NUM_CLASS(2), .DATA_W(7), .COEF_W(16), .ACC_W(16)) b2 ();

  innerproduct_mac_stream #(.N_FEAT(4), .NUM_CLASS(2), .DATA_W(7), .COEF_W(16), .ACC_W(32),
    .FRAC_BITS(16), .SAT(0)) u_dut (.clk(clk), .rst(rst), .bus(b0));
  innerproduct_mac_stream #(.N_FEAT(4), .NUM_CLASS(2), .DATA_W(7), .COEF_W(16), .ACC_W(16),
    .FRAC_BITS(0), .SAT(1)) u_sat (.clk(clk), .rst(rst), .bus(b1));
  innerproduct_mac_stream #(.N_FEAT(4), .NUM_CLASS(2), .DATA_W(7), .COEF_W(16), .ACC_W(16),
    .FRAC_BITS(0), .SAT(0)) u_wrap (.clk(clk), .rst(rst), .bus(b2));

  task automatic wr0(input int cls, input int addr, input int data);
    b0.coef_we = 1'b1; b0.coef_class = 1'(cls); b0.coef_addr = 3'(addr); b0.coef_data = 16'(data);
    @(negedge clk);
    b0.coef_we = 1'b0;
  endtask

  task automatic load_basic();
    int l0[5] = '{1, 2, -3, 0, 5};
    int l1[5] = '{0, 1, 1, 1, 1};
    for (int a = 0; a < 5; a++) begin
      wr0(0, a, l0[a]);
      wr0(1, a, l1[a]);
    end
  endtask

  // Pixels 10,20,30,40; in_last on beat last_at; a locked-out coef write on beat lock_at.
  task automatic send0(input int n, input int last_at, input int lock_at);
    int px[4] = '{10, 20, 30, 40};
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      while (!b0.in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        total++; bad++;
        $display("FAIL send_ready_timeout beat=%0d got in_ready=0 want 1", i);
      end
      b0.in_valid = 1'b1; b0.in_data = 7'(px[i]); b0.in_last = (i == last_at);
      if (i == lock_at) begin
        b0.coef_we = 1'b1; b0.coef_class = 1'b0; b0.coef_addr = 3'd1; b0.coef_data = 16'd100;
      end
      @(negedge clk);
      b0.coef_we = 1'b0;
    end
    b0.in_valid = 1'b0; b0.in_last = 1'b0;
  endtask

  task automatic wait_valid0(input string name);
    int guard = 0;
    while (!b0.out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (!b0.out_valid) begin
      bad++;
      $display("FAIL %s_valid_timeout got out_valid=0 want 1", name);
    end
  endtask

  task automatic ack0();
    b0.out_ready = 1'b1;
    @(negedge clk);
    b0.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (b0.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", b0.out_valid); end
    total++; if (b0.out_data !== 64'd0) begin bad++; $display("FAIL rst_out_data got=%h want=0", b0.out_data); end
    total++; if (b0.out_argmax !== 1'b0) begin bad++; $display("FAIL rst_argmax got=%b want=0", b0.out_argmax); end
    total++; if (b0.out_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", b0.out_err); end
    total++; if (b0.coef_busy !== 1'b0) begin bad++; $display("FAIL rst_coef_busy got=%b want=0", b0.coef_busy); end
    total++; if (b0.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", b0.in_ready); end
    rst = 1'b0;
    #1;
    total++; if (b0.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%b want=1", b0.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_basic();
    send0(4, 3, -1);
    total++; if (b0.out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got out_valid=%b want=1", b0.out_valid); end
    total++; if (b0.coef_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_hold got=%b want=1", b0.coef_busy); end
    total++; if (b0.in_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_hold got=%b want=0", b0.in_ready); end
    total++; if ($signed(b0.out_data[31:0]) !== 32'sd65696) begin bad++; $display("FAIL basic_lane0 got=%0d want=65696", $signed(b0.out_data[31:0])); end
    total++; if ($signed(b0.out_data[63:32]) !== 32'sd100) begin bad++; $display("FAIL basic_lane1 got=%0d want=100", $signed(b0.out_data[63:32])); end
    total++; if (b0.out_argmax !== 1'b0) begin bad++; $display("FAIL basic_argmax got=%0d want=0", b0.out_argmax); end
    total++; if (b0.out_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", b0.out_err); end
    ack0();
    total++; if (b0.out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b want=0", b0.out_valid); end
    total++; if (b0.in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%b want=1", b0.in_ready); end
    total++; if ($signed(b0.out_data[31:0]) !== 32'sd65696) begin bad++; $display("FAIL basic_data_kept got=%0d want=65696", $signed(b0.out_data[31:0])); end
  endtask

  task automatic test_backpressure();
    send0(4, 3, -1);
    b0.in_valid = 1'b1; b0.in_data = 7'd127; b0.in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++; if (b0.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", k, b0.out_valid); end
      total++; if ($signed(b0.out_data[31:0]) !== 32'sd65696) begin bad++; $display("FAIL bp_lane0 cyc=%0d got=%0d want=65696", k, $signed(b0.out_data[31:0])); end
      total++; if (b0.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", k, b0.in_ready); end
      @(negedge clk);
    end
    b0.in_valid = 1'b0; b0.in_last = 1'b0;
    ack0();
    send0(4, 3, -1);
    wait_valid0("bp2");
    total++; if ($signed(b0.out_data[31:0]) !== 32'sd65696) begin bad++; $display("FAIL bp2_lane0 got=%0d want=65696", $signed(b0.out_data[31:0])); end
    total++; if ($signed(b0.out_data[63:32]) !== 32'sd100) begin bad++; $display("FAIL bp2_lane1 got=%0d want=100", $signed(b0.out_data[63:32])); end
    total++; if (b0.out_err !== 1'b0) begin bad++; $display("FAIL bp2_err got=%b want=0", b0.out_err); end
    ack0();
  endtask

  task automatic test_len_errors();
    send0(2, 1, -1);
    wait_valid0("early");
    total++; if ($signed(b0.out_data[31:0]) !== 32'sd65496) begin bad++; $display("FAIL early_lane0 got=%0d want=65496", $signed(b0.out_data[31:0])); end
    total++; if ($signed(b0.out_data[63:32]) !== 32'sd30) begin bad++; $display("FAIL early_lane1 got=%0d want=30", $signed(b0.out_data[63:32])); end
    total++; if (b0.out_err !== 1'b1) begin bad++; $display("FAIL early_err got=%b want=1", b0.out_err); end
    ack0();
    send0(4, -1, -1);
    wait_valid0("nolast");
    total++; if ($signed(b0.out_data[31:0]) !== 32'sd65696) begin bad++; $display("FAIL nolast_lane0 got=%0d want=65696", $signed(b0.out_data[31:0])); end
    total++; if ($signed(b0.out_data[63:32]) !== 32'sd100) begin bad++; $display("FAIL nolast_lane1 got=%0d want=100", $signed(b0.out_data[63:32])); end
    total++; if (b0.out_err !== 1'b1) begin bad++; $display("FAIL nolast_err got=%b want=1", b0.out_err); end
    ack0();
    send0(1, 0, -1);
    wait_valid0("single");
    total++; if ($signed(b0.out_data[31:0]) !== 32'sd65556) begin bad++; $display("FAIL single_lane0 got=%0d want=65556", $signed(b0.out_data[31:0])); end
    total++; if (b0.out_err !== 1'b1) begin bad++; $display("FAIL single_err got=%b want=1", b0.out_err); end
    ack0();
  endtask

  task automatic test_ties_lock();
    int t0[5] = '{0, 1, 1, 1, 1};
    for (int a = 0; a < 5; a++) wr0(0, a, t0[a]);
    send0(4, 3, -1);
    wait_valid0("tie");
    total++; if ($signed(b0.out_data[31:0]) !== 32'sd100) begin bad++; $display("FAIL tie_lane0 got=%0d want=100", $signed(b0.out_data[31:0])); end
    total++; if (b0.out_argmax !== 1'b0) begin bad++; $display("FAIL tie_argmax got=%0d want=0", b0.out_argmax); end
    ack0();
    send0(4, 3, 1);
    wait_valid0("lock1");
    ack0();
    send0(4, 3, -1);
    wait_valid0("lock2");
    total++; if ($signed(b0.out_data[31:0]) !== 32'sd100) begin bad++; $display("FAIL lock_lane0 got=%0d want=100", $signed(b0.out_data[31:0])); end
    ack0();
    wr0(1, 0, 1);
    send0(4, 3, -1);
    wait_valid0("arg1");
    total++; if ($signed(b0.out_data[63:32]) !== 32'sd65636) begin bad++; $display("FAIL arg1_lane1 got=%0d want=65636", $signed(b0.out_data[63:32])); end
    total++; if (b0.out_argmax !== 1'b1) begin bad++; $display("FAIL arg1_argmax got=%0d want=1", b0.out_argmax); end
    ack0();
  endtask

  task automatic test_reset_midframe();
    load_basic();
    send0(2, -1, -1);
    total++; if (b0.coef_busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", b0.coef_busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (b0.out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", b0.out_valid); end
    total++; if (b0.coef_busy !== 1'b0) begin bad++; $display("FAIL mid_idle got busy=%b want=0", b0.coef_busy); end
    send0(4, 3, -1);
    total++; if (b0.out_valid !== 1'b1) begin bad++; $display("FAIL mid_latency got=%b want=1", b0.out_valid); end
    total++; if ($signed(b0.out_data[31:0]) !== 32'sd65696) begin bad++; $display("FAIL mid_lane0 got=%0d want=65696", $signed(b0.out_data[31:0])); end
    total++; if ($signed(b0.out_data[63:32]) !== 32'sd100) begin bad++; $display("FAIL mid_lane1 got=%0d want=100", $signed(b0.out_data[63:32])); end
    total++; if (b0.out_err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b want=0", b0.out_err); end
    ack0();
  endtask

  task automatic test_overflow();
    for (int a = 0; a < 5; a++) begin
      for (int c = 0; c < 2; c++) begin
        b1.coef_we = 1'b1; b1.coef_class = 1'(c); b1.coef_addr = 3'(a);
        b1.coef_data = (c == 0 && a > 0) ? 16'd32767 : 16'd0;
        b2.coef_we = 1'b1; b2.coef_class = b1.coef_class; b2.coef_addr = b1.coef_addr;
        b2.coef_data = b1.coef_data;
        @(negedge clk);
      end
    end
    b1.coef_we = 1'b0; b2.coef_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b1.in_valid = 1'b1; b1.in_data = 7'd127; b1.in_last = (i == 3);
      b2.in_valid = 1'b1; b2.in_data = 7'd127; b2.in_last = (i == 3);
      @(negedge clk);
    end
    b1.in_valid = 1'b0; b1.in_last = 1'b0; b2.in_valid = 1'b0; b2.in_last = 1'b0;
    total++; if (b1.out_valid !== 1'b1 || b2.out_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b%b want=11", b1.out_valid, b2.out_valid); end
    total++; if ($signed(b1.out_data[15:0]) !== 16'sd32767) begin bad++; $display("FAIL sat_lane0 got=%0d want=32767", $signed(b1.out_data[15:0])); end
    total++; if ($signed(b2.out_data[15:0]) !== -16'sd508) begin bad++; $display("FAIL wrap_lane0 got=%0d want=-508", $signed(b2.out_data[15:0])); end
    total++; if (b1.out_argmax !== 1'b0) begin bad++; $display("FAIL sat_argmax got=%0d want=0", b1.out_argmax); end
    total++; if (b2.out_argmax !== 1'b1) begin bad++; $display("FAIL wrap_argmax got=%0d want=1", b2.out_argmax); end
    b1.out_ready = 1'b1; b2.out_ready = 1'b1;
    @(negedge clk);
    b1.out_ready = 1'b0; b2.out_ready = 1'b0;
  endtask

  initial begin
    b0.coef_we = 1'b0; b0.coef_class = '0; b0.coef_addr = '0; b0.coef_data = '0;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.in_last = 1'b0; b0.out_ready = 1'b0;
    b1.coef_we = 1'b0; b1.coef_class = '0; b1.coef_addr = '0; b1.coef_data = '0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.in_last = 1'b0; b1.out_ready = 1'b0;
    b2.coef_we = 1'b0; b2.coef_class = '0; b2.coef_addr = '0; b2.coef_data = '0;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.in_last = 1'b0; b2.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_len_errors();
    test_ties_lock();
    test_reset_midframe();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
